// File: rtl/p16_uart_pkg.sv
// Shared UART definitions: state encoding, rate helper and default parameters
// used by the transmitter and the future receiver.
package p16_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_t;

  localparam int DEF_CLK_HZ    = 12_000_000;
  localparam int DEF_BAUD      = 115_200;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_STOP_BITS = 1;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/p16_uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period. A synchronous clear parks the count at zero.
module p16_uart_baud_tick #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  output logic          bit_end,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bit_end = (cnt_q == LAST);
  assign count   = cnt_q;

endmodule

// File: rtl/p16_uart_fifo_tx.sv
// UART transmitter draining a one-cycle-latency FIFO read port onto an idle-high
// serial line, LSB first. Define P16_UART_TX_PARITY_EN to add an even parity bit.
module p16_uart_fifo_tx
  import p16_uart_pkg::*;
#(
  parameter int CLK_HZ    = DEF_CLK_HZ,
  parameter int BAUD      = DEF_BAUD,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int STOP_BITS = DEF_STOP_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  output logic                 o_fifo_rd_en,
  input  logic [DATA_BITS-1:0] i_fifo_rd_data,
  input  logic                 i_fifo_rd_valid,
  input  logic                 i_fifo_empty,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_byte_done,
  output tx_state_t            o_state
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam int BCW = $clog2(DATA_BITS);

  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);
  localparam logic [CW-1:0]  PRE_END   = CW'(CPB - 2);

  if (CPB < 2) begin : g_bad_rate
    $error("p16_uart_fifo_tx: CLK_HZ / BAUD must be at least 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
    $error("p16_uart_fifo_tx: STOP_BITS must be 1 or 2");
  end

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 rd_en_q, rd_en_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 baud_clr;
  logic                 bit_end;
  logic [CW-1:0]        baud_cnt;
`ifdef P16_UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  p16_uart_baud_tick #(
    .CLKS_PER_BIT(CPB),
    .CW          (CW)
  ) u_baud (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clear  (baud_clr),
    .bit_end(bit_end),
    .count  (baud_cnt)
  );

  // Outputs are registered from next-state values so they line up with state_q.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    baud_clr  = 1'b0;
`ifdef P16_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        baud_clr = 1'b1;
        if (rd_en_q) state_d = FETCH;
      end
      FETCH: begin
        baud_clr = 1'b1;
        if (i_fifo_rd_valid) begin
          shift_d   = i_fifo_rd_data;
          bit_cnt_d = '0;
          state_d   = START;
`ifdef P16_UART_TX_PARITY_EN
          parity_d  = ^i_fifo_rd_data;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
`ifdef P16_UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef P16_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The pop request leads FETCH by one cycle so read data lands in FETCH.
    rd_en_d = (state_d == IDLE) && !rd_en_q && i_enable && !i_fifo_empty;
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == STOP) && (bit_cnt_q == STOP_LAST) && (baud_cnt == PRE_END);

    tx_d = 1'b1;
    if (state_d == START) tx_d = 1'b0;
    if (state_d == DATA)  tx_d = shift_d[0];
`ifdef P16_UART_TX_PARITY_EN
    if (state_d == PARITY) tx_d = parity_d;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      rd_en_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      rd_en_q   <= rd_en_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef P16_UART_TX_PARITY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) parity_q <= 1'b0;
    else          parity_q <= parity_d;
  end
`endif

  assign o_fifo_rd_en = rd_en_q;
  assign o_tx         = tx_q;
  assign o_busy       = busy_q;
  assign o_byte_done  = done_q;
  assign o_state      = state_q;

endmodule
